requant_arb: RTL and testbench
==============================

Name: requant_arb

Overview:
- Shares one combinational requant datapath (scale multiply, arithmetic shift, int8 clamp) between NREQ accumulator requesters, e.g. matmul lanes or attention heads.
- Round-robin arbitration; one requant per cycle.
- Holds a per-requester scale register bank written through a config port.
- Registers the int8 result with the requester ID behind a valid/ready output.

Parameters:
- NREQ, 4, number of requesters (>=2).
- ACC_W, 24, signed accumulator width per requester.
- SCALE_W, 16, unsigned scale width.
- SHIFT, 22, right shift applied to acc*scale.
- ID_W (localparam), $clog2(NREQ), requester index width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  NREQ  per-requester valid.
- req_acc_i  in  NREQ*ACC_W  packed signed accumulators; requester r at bits [r*ACC_W +: ACC_W].
- req_ready_o  out  NREQ  per-requester accept; one-hot or zero.
- cfg_we_i  in  1  scale register write strobe.
- cfg_idx_i  in  ID_W  scale register index.
- cfg_scale_i  in  SCALE_W  scale value.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accept.
- out_q_o  out  8  signed int8 result.
- out_id_o  out  ID_W  requester that produced out_q_o.

Behaviour:
Reset (asynchronous, on rst_ni low):
- out_valid_o=0, out_q_o=0, out_id_o=0.
- Round-robin pointer=0.
- All scale registers = 2^(SCALE_W-1), i.e. shift-only encoding.
- Any in-flight result is discarded; nothing is replayed after reset.

Output register and accept:
- Output register is a single stage; `can_accept = !out_valid_o || out_ready_i`.

Arbitration (combinational):
- Search starts at pointer and wraps modulo NREQ; the first r with req_valid_i[r]=1 is the grant g.
- req_ready_o[g] = can_accept. All other bits are 0.
- req_ready_o may depend combinationally on req_valid_i and out_ready_i. Requesters must not make valid depend on ready.

Transfer:
- A transfer occurs when req_valid_i[g] && req_ready_o[g].
- On that edge: out_q_o <= requant(req_acc_i[g], scale[g]), out_id_o <= g, out_valid_o <= 1, pointer <= (g+1) mod NREQ.
- Latency: result visible the cycle after acceptance.

No transfer:
- If out_valid_o && out_ready_i with no transfer, out_valid_o <= 0.
- Pointer changes only on a transfer.
- While out_valid_o && !out_ready_i, out_q_o and out_id_o hold stable and all req_ready_o are 0.

Throughput:
- One result per cycle when out_ready_i is held high.
- Two or more requesters continuously valid are served in strict rotation.

Requant arithmetic:
- product = acc (signed ACC_W) * {0,scale} (signed SCALE_W+1), held at full ACC_W+SCALE_W width.
- Arithmetic shift right by SHIFT (floor toward -inf).
- Clamp to [-128,127].

Config writes:
- On cfg_we_i the edge writes scale[cfg_idx_i] <= cfg_scale_i.
- A write and a transfer from the same index on the same edge: the transfer uses the old scale.
- cfg_idx_i >= NREQ: the write is ignored.
- Writes are accepted in any state, including while the output is stalled.

Optional Feature:
- Macro: REQUANT_ARB_SAT_CNT_EN.
- Enabled, adds outputs:
  - sat_cnt_o (16 bits): counts transfers whose pre-clamp shifted value was >127 or <-128. Saturates at 16'hFFFF, resets to 0.
  - sat_clr_i (1 bit): synchronous clear; a clear wins over an increment on the same edge.
- Disabled: neither port exists; behaviour is otherwise identical.

Test Plan:
- Reset defaults: NREQ=4; req 0 valid, acc=1280, default scale 0x8000 -> after one edge out_valid_o=1, out_q_o=10 (1280*2^15>>22), out_id_o=0.
- Clamp: after scale[2]=0x8000:
  - acc=24'sh7FFFFF -> 127.
  - acc=24'sh800000 -> -128.
  - acc=-1 -> -1 (floor).
- Round-robin: all four requesters valid continuously, out_ready_i=1 -> out_id_o sequence 0,1,2,3,0,1 on consecutive cycles, one result per cycle.
- Backpressure: out_ready_i=0 for 3 cycles with req 1 valid -> output holds value and ID, req_ready_o=0; on release, the next grant follows the stored pointer.
- Config race: cfg_we_i to idx 3 (scale 0x4000) on the same edge req 3 is accepted with acc=2560 -> result uses old 0x8000 (20); next req 3 acc=2560 -> 10.
- Async reset while out_valid_o=1 and stalled -> out_valid_o drops immediately; after deassert, pointer=0 and scales restored to 0x8000.
- With REQUANT_ARB_SAT_CNT_EN, 5 saturating transfers -> sat_cnt_o=5; sat_clr_i asserted on the same edge as a saturating transfer -> sat_cnt_o=0.

Source files
------------

// File: rtl/requant_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | requant_arb: round-robin shared int8 requant (scale, ashr, clamp), Rev 1.0 |
// | Optional saturation counter: define REQUANT_ARB_SAT_CNT_EN                 |
// +--------------------------------------------------------------------------+
module requant_arb #(
   parameter  int NREQ    = 4,
   parameter  int ACC_W   = 24,
   parameter  int SCALE_W = 16,
   parameter  int SHIFT   = 22,
   localparam int ID_W    = $clog2(NREQ)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [NREQ-1:0]         req_valid_i,
   input  logic [NREQ*ACC_W-1:0]   req_acc_i,
   output logic [NREQ-1:0]         req_ready_o,
   input  logic                    cfg_we_i,
   input  logic [ID_W-1:0]         cfg_idx_i,
   input  logic [SCALE_W-1:0]      cfg_scale_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic signed [7:0]       out_q_o,
   output logic [ID_W-1:0]         out_id_o
`ifdef REQUANT_ARB_SAT_CNT_EN
   ,
   input  logic                    sat_clr_i,
   output logic [15:0]             sat_cnt_o
`endif
);

   localparam int                       PROD_W    = ACC_W + SCALE_W + 1;
   localparam logic signed [PROD_W-1:0] C_MAX     = PROD_W'(127);
   localparam logic signed [PROD_W-1:0] C_MIN     = PROD_W'(-128);
   localparam logic [SCALE_W-1:0]       SCALE_RST = {1'b1, {(SCALE_W-1){1'b0}}};

   logic [SCALE_W-1:0]       scale_q [NREQ];
   logic [SCALE_W-1:0]       scale_d [NREQ];
   logic [ID_W-1:0]          ptr_q, ptr_d;
   logic                     out_valid_q, out_valid_d;
   logic signed [7:0]        out_q_q, out_q_d;
   logic [ID_W-1:0]          out_id_q, out_id_d;

   logic [ID_W-1:0]          grant;
   logic                     found;
   logic                     can_accept;
   logic                     xfer;
   logic signed [ACC_W-1:0]  acc_sel;
   logic [SCALE_W-1:0]       scale_sel;
   logic signed [PROD_W-1:0] prod;
   logic signed [PROD_W-1:0] shifted;
   logic signed [7:0]        q_clamped;

   assign can_accept = !out_valid_q || out_ready_i;

   // First valid requester at or after the pointer, wrapping modulo NREQ.
   always_comb begin
      int idx;
      found = 1'b0;
      grant = '0;
      idx   = 0;
      for (int i = 0; i < NREQ; i++) begin
         idx = (int'(ptr_q) + i) % NREQ;
         if (!found && req_valid_i[idx]) begin
            found = 1'b1;
            grant = ID_W'(idx);
         end
      end
   end

   assign xfer = found && can_accept;

   always_comb begin
      req_ready_o = '0;
      for (int r = 0; r < NREQ; r++) begin
         req_ready_o[r] = xfer && (grant == ID_W'(r));
      end
   end

   // Scale is zero-extended so the multiply stays signed; shift floors toward -inf.
   always_comb begin
      acc_sel   = req_acc_i[int'(grant)*ACC_W +: ACC_W];
      scale_sel = scale_q[grant];
      prod      = PROD_W'(acc_sel) * PROD_W'($signed({1'b0, scale_sel}));
      shifted   = prod >>> SHIFT;
      if (shifted > C_MAX) begin
         q_clamped = 8'sd127;
      end else if (shifted < C_MIN) begin
         q_clamped = -8'sd128;
      end else begin
         q_clamped = shifted[7:0];
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_q_d     = out_q_q;
      out_id_d    = out_id_q;
      ptr_d       = ptr_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_q_d     = q_clamped;
         out_id_d    = grant;
         ptr_d       = (int'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
      end else if (out_ready_i) begin
         out_valid_d = 1'b0;
      end
   end

   // Writes land at the edge, so a same-edge transfer already used the old scale.
   always_comb begin
      for (int r = 0; r < NREQ; r++) begin
         scale_d[r] = scale_q[r];
      end
      if (cfg_we_i && (int'(cfg_idx_i) < NREQ)) begin
         scale_d[cfg_idx_i] = cfg_scale_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_valid_q <= 1'b0;
         out_q_q     <= 8'sd0;
         out_id_q    <= '0;
         ptr_q       <= '0;
         for (int r = 0; r < NREQ; r++) begin
            scale_q[r] <= SCALE_RST;
         end
      end else begin
         out_valid_q <= out_valid_d;
         out_q_q     <= out_q_d;
         out_id_q    <= out_id_d;
         ptr_q       <= ptr_d;
         for (int r = 0; r < NREQ; r++) begin
            scale_q[r] <= scale_d[r];
         end
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_q_o     = out_q_q;
   assign out_id_o    = out_id_q;

`ifdef REQUANT_ARB_SAT_CNT_EN
   logic        sat;
   logic [15:0] sat_cnt_q, sat_cnt_d;

   assign sat = (shifted > C_MAX) || (shifted < C_MIN);

   always_comb begin
      sat_cnt_d = sat_cnt_q;
      if (sat_clr_i) begin
         sat_cnt_d = 16'h0000;
      end else if (xfer && sat && (sat_cnt_q != 16'hFFFF)) begin
         sat_cnt_d = sat_cnt_q + 16'h0001;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sat_cnt_q <= 16'h0000;
      end else begin
         sat_cnt_q <= sat_cnt_d;
      end
   end

   assign sat_cnt_o = sat_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_requant_arb.sv
`default_nettype none
// tb_requant_arb: directed self-checking bench for requant_arb (NREQ=4, ACC_W=24).
module tb_requant_arb;
   localparam int NREQ  = 4;
   localparam int ACC_W = 24;
   localparam int ID_W  = 2;

   logic                  clk;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*ACC_W-1:0] req_acc;
   logic [NREQ-1:0]       req_ready;
   logic                  cfg_we;
   logic [ID_W-1:0]       cfg_idx;
   logic [15:0]           cfg_scale;
   logic                  out_valid;
   logic                  out_ready;
   logic signed [7:0]     out_q;
   logic [ID_W-1:0]       out_id;
`ifdef REQUANT_ARB_SAT_CNT_EN
   logic                  sat_clr;
   logic [15:0]           sat_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   requant_arb #(.NREQ(NREQ), .ACC_W(ACC_W), .SCALE_W(16), .SHIFT(22)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_valid_i (req_valid),
      .req_acc_i   (req_acc),
      .req_ready_o (req_ready),
      .cfg_we_i    (cfg_we),
      .cfg_idx_i   (cfg_idx),
      .cfg_scale_i (cfg_scale),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_q_o     (out_q),
      .out_id_o    (out_id)
`ifdef REQUANT_ARB_SAT_CNT_EN
      ,
      .sat_clr_i   (sat_clr),
      .sat_cnt_o   (sat_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_acc(input int r, input logic [23:0] v);
      req_acc[r*ACC_W +: ACC_W] = v;
   endtask

   task automatic check_out(input string tag, input int v, input int q, input int id);
      check({tag, ".valid"}, 32'(out_valid), 32'(v));
      check({tag, ".q"},     out_q,          q);
      check({tag, ".id"},    32'(out_id),    32'(id));
   endtask

   logic [23:0] clamp_acc [8];
   int          clamp_exp [8];

   initial begin
      clamp_acc = '{24'h7FFFFF, 24'h800000, 24'hFFFFFF, 24'd16256,
                    24'd16384,  24'hFFC000, 24'hFFBFFF, 24'hFFFB00};
      clamp_exp = '{127, -128, -1, 127, 127, -128, -128, -10};

      rst_n     = 1'b0;
      req_valid = '0;
      req_acc   = '0;
      cfg_we    = 1'b0;
      cfg_idx   = '0;
      cfg_scale = '0;
      out_ready = 1'b1;
`ifdef REQUANT_ARB_SAT_CNT_EN
      sat_clr   = 1'b0;
`endif
      step();
      step();
      check_out("reset", 0, 0, 0);
      #2 rst_n = 1'b1;

      // Default scale 0x8000: 1280 * 2^15 >> 22 = 10
      req_valid = 4'b0001;
      set_acc(0, 24'd1280);
      #1 check("t1.ready", 32'(req_ready), 32'h1);
      step();
      check_out("t1", 1, 10, 0);
      req_valid = '0;
      step();
      check("drain.valid", 32'(out_valid), 0);

      cfg_we = 1'b1; cfg_idx = 2'd2; cfg_scale = 16'h8000;
      step();
      cfg_we = 1'b0;

      req_valid = 4'b0100;
      for (int k = 0; k < 8; k++) begin
         set_acc(2, clamp_acc[k]);
         step();
         check_out($sformatf("clamp%0d", k), 1, clamp_exp[k], 2);
      end

      // Pointer is now 3; serve req 3 once to bring it back to 0.
      req_valid = 4'b1000;
      set_acc(3, 24'd0);
      step();
      check_out("wrap", 1, 0, 3);

      req_valid = 4'b1111;
      for (int r = 0; r < NREQ; r++) set_acc(r, 24'((r + 1) * 128));
      #1 check("rr.ready0", 32'(req_ready), 32'h1);
      for (int k = 0; k < 6; k++) begin
         step();
         check_out($sformatf("rr%0d", k), 1, (k % 4) + 1, k % 4);
      end

      // Pointer = 2, output holds id 1 / q 2; stall with req 1 and 3 valid.
      out_ready = 1'b0;
      req_valid = 4'b1010;
      set_acc(3, 24'd512);
      #1 check("stall.ready", 32'(req_ready), 0);
      for (int k = 0; k < 3; k++) begin
         step();
         check_out($sformatf("stall%0d", k), 1, 2, 1);
         check($sformatf("stall%0d.ready", k), 32'(req_ready), 0);
      end
      out_ready = 1'b1;
      #1 check("release.ready", 32'(req_ready), 32'h8);
      step();
      check_out("release", 1, 4, 3);
      check("next.ready", 32'(req_ready), 32'h2);
      step();
      check_out("next", 1, 2, 1);

      // Same-edge config write to idx 3 must not affect this transfer.
      req_valid = 4'b1000;
      set_acc(3, 24'd2560);
      cfg_we = 1'b1; cfg_idx = 2'd3; cfg_scale = 16'h4000;
      step();
      cfg_we = 1'b0;
      check_out("race.old", 1, 20, 3);
      step();
      check_out("race.new", 1, 10, 3);

      req_valid = '0;
      cfg_we = 1'b1; cfg_idx = 2'd0; cfg_scale = 16'h2000;
      step();
      cfg_we = 1'b0;
      out_ready = 1'b0;
      req_valid = 4'b0010;
      set_acc(1, 24'd640);
      step();
      check_out("prerst", 1, 5, 1);
      req_valid = '0;
      step();
      check_out("prerst.hold", 1, 5, 1);
      #2 rst_n = 1'b0;
      #1 check_out("async_rst", 0, 0, 0);
      #2 rst_n = 1'b1;

      out_ready = 1'b1;
      req_valid = 4'b1111;
      set_acc(0, 24'd1280);
      #1 check("postrst.ready", 32'(req_ready), 32'h1);
      step();
      check_out("postrst", 1, 10, 0);

`ifdef REQUANT_ARB_SAT_CNT_EN
      req_valid = '0;
      step();
      check("sat.init", 32'(sat_cnt), 0);
      req_valid = 4'b0001;
      set_acc(0, 24'h7FFFFF);
      for (int k = 0; k < 5; k++) step();
      check("sat.five", 32'(sat_cnt), 5);
      sat_clr = 1'b1;
      step();
      sat_clr = 1'b0;
      check("sat.clr", 32'(sat_cnt), 0);
      step();
      check("sat.after", 32'(sat_cnt), 1);
      req_valid = '0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
